// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU/bus encodings, CCR bit indices and control states for the 8-bit CPU
package cpu_pkg;
  localparam logic [7:0] LDA_IMM = 8'h86;
  localparam logic [7:0] LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88;
  localparam logic [7:0] LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96;
  localparam logic [7:0] STB_DIR = 8'h97;
  localparam logic [7:0] ADD_AB  = 8'h42;
  localparam logic [7:0] SUB_AB  = 8'h43;
  localparam logic [7:0] AND_AB  = 8'h44;
  localparam logic [7:0] OR_AB   = 8'h45;
  localparam logic [7:0] INCA    = 8'h46;
  localparam logic [7:0] INCB    = 8'h47;
  localparam logic [7:0] DECA    = 8'h48;
  localparam logic [7:0] DECB    = 8'h49;
  localparam logic [7:0] BRA     = 8'h20;
  localparam logic [7:0] BMI     = 8'h21;
  localparam logic [7:0] BPL     = 8'h22;
  localparam logic [7:0] BEQ     = 8'h23;
  localparam logic [7:0] BNE     = 8'h24;
  localparam logic [7:0] BVS     = 8'h25;
  localparam logic [7:0] BVC     = 8'h26;
  localparam logic [7:0] BCS     = 8'h27;
  localparam logic [7:0] BCC     = 8'h28;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_INCA = 3'b100;
  localparam logic [2:0] ALU_DECA = 3'b101;
  localparam logic [2:0] ALU_INCB = 3'b110;
  localparam logic [2:0] ALU_DECB = 3'b111;
  localparam logic [1:0] FROM_ALU = 2'b00;
  localparam logic [1:0] FROM_BUS = 2'b01;
  localparam logic [1:0] FROM_MEM = 2'b10;
  localparam logic [1:0] TO_PC    = 2'b00;
  localparam logic [1:0] TO_A     = 2'b01;
  localparam logic [1:0] TO_B     = 2'b10;
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;
  typedef enum logic [3:0] {
    FETCH_0, FETCH_1, FETCH_2, DECODE_3, S4, S5, S6, S7, S8
  } state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_LD_IMM, OP_LD_DIR, OP_ST_DIR, OP_ALU, OP_BRANCH
  } op_class_t;
  // Groups opcodes by the execute sequence they need.
  function automatic op_class_t op_class(input logic [7:0] ir);
    case (ir)
      LDA_IMM, LDB_IMM: return OP_LD_IMM;
      LDA_DIR, LDB_DIR: return OP_LD_DIR;
      STA_DIR, STB_DIR: return OP_ST_DIR;
      ADD_AB, SUB_AB, AND_AB, OR_AB, INCA, INCB, DECA, DECB: return OP_ALU;
      BRA, BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC: return OP_BRANCH;
      default: return OP_NOP;
    endcase
  endfunction
  // ALU operation selected by an ALU-class opcode.
  function automatic logic [2:0] alu_code(input logic [7:0] ir);
    case (ir)
      SUB_AB:  return ALU_SUB;
      AND_AB:  return ALU_AND;
      OR_AB:   return ALU_OR;
      INCA:    return ALU_INCA;
      DECA:    return ALU_DECA;
      INCB:    return ALU_INCB;
      DECB:    return ALU_DECB;
      default: return ALU_ADD;
    endcase
  endfunction
  // Branch condition evaluated against the NZVC flags.
  function automatic logic branch_taken(input logic [7:0] ir, input logic [3:0] ccr);
    case (ir)
      BRA:     return 1'b1;
      BMI:     return ccr[CCR_N];
      BPL:     return !ccr[CCR_N];
      BEQ:     return ccr[CCR_Z];
      BNE:     return !ccr[CCR_Z];
      BVS:     return ccr[CCR_V];
      BVC:     return !ccr[CCR_V];
      BCS:     return ccr[CCR_C];
      BCC:     return !ccr[CCR_C];
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving the 8-bit CPU data path strobes
module control_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] IR,
  input  logic [3:0]       CCR,
  output logic             IR_LOAD,
  output logic             MAR_LOAD,
  output logic             PC_LOAD,
  output logic             PC_INC,
  output logic             A_LOAD,
  output logic             B_LOAD,
  output logic             CCR_LOAD,
  output logic [2:0]       ALU_SEL,
  output logic [1:0]       FROM_MEMORY_BUS_SEL,
  output logic [1:0]       TO_MEMORY_BUS_SEL,
  output logic             write
);
  state_t    state, next_state;
  op_class_t op;
  logic      taken;
  logic      dest_b;
  assign op     = op_class(IR);
  assign dest_b = (IR == INCB) || (IR == DECB);
  // State register; the branch decision is captured once in DECODE_3 so later CCR changes cannot alter it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH_0;
      taken <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE_3) taken <= branch_taken(IR, CCR);
    end
  // Next-state selection; anything unencoded falls back to FETCH_0.
  always_comb begin
    next_state = FETCH_0;
    case (state)
      FETCH_0:  next_state = FETCH_1;
      FETCH_1:  next_state = FETCH_2;
      FETCH_2:  next_state = DECODE_3;
      DECODE_3: next_state = (op == OP_NOP) ? FETCH_0 : S4;
      S4:       next_state = (op == OP_ALU) ? FETCH_0 : S5;
      S5:       next_state = (op == OP_BRANCH && !taken) ? FETCH_0 : S6;
      S6:       next_state = (op == OP_LD_DIR || op == OP_ST_DIR) ? S7 : FETCH_0;
      S7:       next_state = (op == OP_LD_DIR) ? S8 : FETCH_0;
      default:  next_state = FETCH_0;
    endcase
  end
  // Output decode from state and IR; reset blanks every strobe immediately.
  always_comb begin
    IR_LOAD             = 1'b0;
    MAR_LOAD            = 1'b0;
    PC_LOAD             = 1'b0;
    PC_INC              = 1'b0;
    A_LOAD              = 1'b0;
    B_LOAD              = 1'b0;
    CCR_LOAD            = 1'b0;
    ALU_SEL             = ALU_ADD;
    FROM_MEMORY_BUS_SEL = FROM_ALU;
    TO_MEMORY_BUS_SEL   = TO_PC;
    write               = 1'b0;
    if (!reset)
      case (state)
        FETCH_0: begin
          MAR_LOAD            = 1'b1;
          FROM_MEMORY_BUS_SEL = FROM_BUS;
        end
        FETCH_1: PC_INC = 1'b1;
        FETCH_2: begin
          IR_LOAD             = 1'b1;
          FROM_MEMORY_BUS_SEL = FROM_MEM;
        end
        S4:
          if (op == OP_ALU) begin
            ALU_SEL  = alu_code(IR);
            CCR_LOAD = 1'b1;
            A_LOAD   = !dest_b;
            B_LOAD   = dest_b;
          end else begin
            MAR_LOAD            = 1'b1;
            FROM_MEMORY_BUS_SEL = FROM_BUS;
          end
        S5: PC_INC = (op != OP_BRANCH) || !taken;
        S6: begin
          FROM_MEMORY_BUS_SEL = FROM_MEM;
          MAR_LOAD            = (op == OP_LD_DIR) || (op == OP_ST_DIR);
          PC_LOAD             = (op == OP_BRANCH);
          A_LOAD              = (IR == LDA_IMM);
          B_LOAD              = (IR == LDB_IMM);
        end
        S7: begin
          write             = (op == OP_ST_DIR);
          TO_MEMORY_BUS_SEL = (IR == STA_DIR) ? TO_A : (IR == STB_DIR) ? TO_B : TO_PC;
        end
        S8: begin
          FROM_MEMORY_BUS_SEL = FROM_MEM;
          A_LOAD              = (IR == LDA_DIR);
          B_LOAD              = (IR == LDB_DIR);
        end
        default: ;
      endcase
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore-style FSM that sequences the 8-bit CPU through fetch, decode and execute.
- Sits directly upstream of the data path. It consumes IR and CCR and drives every register load, PC increment, ALU select and bus select into the data path, plus the memory write strobe.
- Memory is combinational-read on address (MAR). Read data is valid the cycle after MAR_LOAD. Writes commit on the clk edge while write=1.

Parameters:
- WIDTH, 8, instruction/data width; IR is WIDTH bits.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high; forces FETCH_0.
- IR, input, 8, current instruction opcode from the data path.
- CCR, input, 4, flags {N,Z,V,C} = bits [3:0].
- IR_LOAD, output, 1, load IR from FROM_MEMORY_BUS.
- MAR_LOAD, output, 1, load MAR from FROM_MEMORY_BUS.
- PC_LOAD, output, 1, load PC from FROM_MEMORY_BUS.
- PC_INC, output, 1, PC <= MAR+1.
- A_LOAD, output, 1, load A.
- B_LOAD, output, 1, load B.
- CCR_LOAD, output, 1, latch ALU NZVC.
- ALU_SEL, output, 3, ALU operation.
- FROM_MEMORY_BUS_SEL, output, 2, 00 ALU result, 01 TO_MEMORY_BUS, 10 from_memory.
- TO_MEMORY_BUS_SEL, output, 2, 00 PC, 01 A, 10 B.
- write, output, 1, memory write enable.

Behaviour:
- Reset: state=FETCH_0. All strobes 0, ALU_SEL=000, both bus selects 00, whether reset is asserted mid-instruction or not. First fetch occurs on the first edge after reset deasserts.
- Outputs are decoded only from state and IR. Any output not listed for a state is 0/00.
- Fetch and decode:
  - FETCH_0: TO_SEL=00, FROM_SEL=01, MAR_LOAD.
  - FETCH_1: PC_INC.
  - FETCH_2: FROM_SEL=10, IR_LOAD.
  - DECODE_3: no strobes; selects the next state from IR and CCR.
- Opcodes:
  - Loads/stores: LDA_IMM 86, LDA_DIR 87, LDB_IMM 88, LDB_DIR 89, STA_DIR 96, STB_DIR 97.
  - ALU: ADD_AB 42, SUB_AB 43, AND_AB 44, OR_AB 45, INCA 46, INCB 47, DECA 48, DECB 49.
  - Branches: BRA 20, BMI 21, BPL 22, BEQ 23, BNE 24, BVS 25, BVC 26, BCS 27, BCC 28.
- Immediate load (LDx_IMM), 3 exec cycles:
  - S4: TO_SEL=00, FROM_SEL=01, MAR_LOAD.
  - S5: PC_INC.
  - S6: FROM_SEL=10, A_LOAD or B_LOAD.
- Direct load (LDx_DIR), 5 exec cycles:
  - S4/S5 as for immediate.
  - S6: FROM_SEL=10, MAR_LOAD.
  - S7: wait.
  - S8: FROM_SEL=10, A_LOAD or B_LOAD.
- Direct store (STx_DIR), 4 exec cycles:
  - S4/S5/S6 as for direct load.
  - S7: TO_SEL=01 (A) or 10 (B), write=1.
- ALU ops, 1 exec cycle:
  - ALU_SEL: ADD 000, SUB 001, AND 010, OR 011, INCA 100, DECA 101, INCB 110, DECB 111.
  - FROM_SEL=00, CCR_LOAD.
  - Destination is A_LOAD, except INCB/DECB which use B_LOAD.
- Branch taken (BRA, or condition true), 3 exec cycles:
  - S4: TO_SEL=00, FROM_SEL=01, MAR_LOAD.
  - S5: wait.
  - S6: FROM_SEL=10, PC_LOAD.
- Branch not taken, 2 exec cycles:
  - S4: TO_SEL=00, FROM_SEL=01, MAR_LOAD.
  - S5: PC_INC (skips the operand).
- Branch conditions, sampled from CCR in DECODE_3 only:
  - BMI N=1, BPL N=0, BEQ Z=1, BNE Z=0, BVS V=1, BVC V=0, BCS C=1, BCC C=0.
- Unknown opcode: NOP; DECODE_3 → FETCH_0.
- After the last exec state, return to FETCH_0. No illegal-state lockup: any unencoded state → FETCH_0.
- At most one of PC_LOAD/PC_INC, and at most one of A_LOAD/B_LOAD, asserted per cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants;
  - ALU_SEL codes;
  - bus-select encodings;
  - CCR bit indices;
  - state enum (FETCH_0..S8).
- The data path and ALU import the same package.
- No sub-module; a single FSM with a next-state block and an output-decode block.

Test Plan:
- Reset asserted mid-LDA_DIR (in S7) → all outputs 0 and next state FETCH_0 immediately; after release, MAR_LOAD=1 with TO_SEL=00, FROM_SEL=01.
- IR=86 → exact strobe sequence MAR_LOAD, PC_INC, IR_LOAD, –, MAR_LOAD, PC_INC, A_LOAD(FROM_SEL=10); 7 cycles total.
- IR=97 → S7 shows write=1, TO_SEL=10; no A_LOAD or B_LOAD anywhere in the instruction.
- IR=47 → exec cycle shows ALU_SEL=110, FROM_SEL=00, B_LOAD=1, CCR_LOAD=1, A_LOAD=0.
- IR=23 with CCR=0100 → PC_LOAD in S6 (taken). Same IR with CCR=0000 → PC_INC in S5, no PC_LOAD, back to FETCH_0.
- IR=FF → DECODE_3 then FETCH_0; no strobe besides the fetch ones.
